mem_bus_arbiter: RTL and testbench

- Shares one external memory bus between the instruction-fetch port and the data load/store port of the core.
- Fixed priority: data over fetch. Each granted access is held on the bus until the slave acks or a watchdog expires.
- Drives a stall request into the pipeline controller while an accepted request has not yet completed.
- Supports abandoning an in-flight fetch on pipeline flush.

---
 rtl/mem_bus_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the fetch port and the load/store port.
// Data has fixed priority over fetch; every access ends on slave ack or watchdog expiry.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    output logic              if_err_o,
    input  logic              dm_ce_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_data_i,
    input  logic [3:0]        dm_sel_i,
    output logic [DATA_W-1:0] dm_data_o,
    output logic              dm_ready_o,
    output logic              dm_err_o,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    output logic [3:0]        bus_sel_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ack_i,
    output logic              stallreq_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DM_ACC  = 3'd1,
        IF_ACC  = 3'd2,
        IF_DROP = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              bus_ce_q, bus_ce_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [7:0]        wd_cnt_q, wd_cnt_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] dm_data_q, dm_data_d;
    logic              if_ready_q, if_ready_d;
    logic              if_err_q, if_err_d;
    logic              dm_ready_q, dm_ready_d;
    logic              dm_err_q, dm_err_d;
    logic              wd_expire;

    assign wd_expire = (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bus_ce_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_sel_q  <= '0;
            wd_cnt_q   <= '0;
            if_data_q  <= '0;
            dm_data_q  <= '0;
            if_ready_q <= 1'b0;
            if_err_q   <= 1'b0;
            dm_ready_q <= 1'b0;
            dm_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_ce_q   <= bus_ce_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            bus_sel_q  <= bus_sel_d;
            wd_cnt_q   <= wd_cnt_d;
            if_data_q  <= if_data_d;
            dm_data_q  <= dm_data_d;
            if_ready_q <= if_ready_d;
            if_err_q   <= if_err_d;
            dm_ready_q <= dm_ready_d;
            dm_err_q   <= dm_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bus_ce_d   = bus_ce_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_sel_d  = bus_sel_q;
        wd_cnt_d   = wd_cnt_q;
        if_data_d  = if_data_q;
        dm_data_d  = dm_data_q;
        if_ready_d = 1'b0;
        if_err_d   = 1'b0;
        dm_ready_d = 1'b0;
        dm_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dm_ce_i) begin
                    bus_ce_d   = 1'b1;
                    bus_we_d   = dm_we_i;
                    bus_addr_d = dm_addr_i;
                    bus_data_d = dm_data_i;
                    bus_sel_d  = dm_sel_i;
                    wd_cnt_d   = '0;
                    state_d    = DM_ACC;
                end else if (if_ce_i && !flush_i) begin
                    bus_ce_d   = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = if_addr_i;
                    bus_data_d = '0;
                    bus_sel_d  = 4'b1111;
                    wd_cnt_d   = '0;
                    state_d    = IF_ACC;
                end
            end

            DM_ACC: begin
                wd_cnt_d = wd_cnt_q + 8'd1;
                if (bus_ack_i) begin
                    bus_ce_d   = 1'b0;
                    bus_we_d   = 1'b0;
                    dm_data_d  = bus_we_q ? '0 : bus_data_i;
                    dm_ready_d = 1'b1;
                    state_d    = DONE;
                end else if (wd_expire) begin
                    bus_ce_d   = 1'b0;
                    bus_we_d   = 1'b0;
                    dm_data_d  = '0;
                    dm_ready_d = 1'b1;
                    dm_err_d   = 1'b1;
                    state_d    = DONE;
                end
            end

            IF_ACC: begin
                wd_cnt_d = wd_cnt_q + 8'd1;
                // A flushed fetch never delivers, even if the slave answers in the same cycle.
                if (flush_i) begin
                    if (bus_ack_i || wd_expire) begin
                        bus_ce_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d  = IF_DROP;
                    end
                end else if (bus_ack_i) begin
                    bus_ce_d   = 1'b0;
                    if_data_d  = bus_data_i;
                    if_ready_d = 1'b1;
                    state_d    = DONE;
                end else if (wd_expire) begin
                    bus_ce_d   = 1'b0;
                    if_data_d  = '0;
                    if_ready_d = 1'b1;
                    if_err_d   = 1'b1;
                    state_d    = DONE;
                end
            end

            IF_DROP: begin
                wd_cnt_d = wd_cnt_q + 8'd1;
                if (bus_ack_i || wd_expire) begin
                    bus_ce_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                bus_ce_d = 1'b0;
                bus_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign bus_ce_o   = bus_ce_q;
    assign bus_we_o   = bus_we_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_data_o = bus_data_q;
    assign bus_sel_o  = bus_sel_q;
    assign if_data_o  = if_data_q;
    assign if_ready_o = if_ready_q;
    assign if_err_o   = if_err_q;
    assign dm_data_o  = dm_data_q;
    assign dm_ready_o = dm_ready_q;
    assign dm_err_o   = dm_err_q;

    assign stallreq_o = (dm_ce_i & ~dm_ready_q) | (if_ce_i & ~if_ready_q & ~flush_i);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 4-cycle watchdog.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        if_err_o;
    logic        dm_ce_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_data_o;
    logic        dm_ready_o;
    logic        dm_err_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        stallreq_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flush_i),
        .if_ce_i(if_ce_i),
        .if_addr_i(if_addr_i),
        .if_data_o(if_data_o),
        .if_ready_o(if_ready_o),
        .if_err_o(if_err_o),
        .dm_ce_i(dm_ce_i),
        .dm_we_i(dm_we_i),
        .dm_addr_i(dm_addr_i),
        .dm_data_i(dm_data_i),
        .dm_sel_i(dm_sel_i),
        .dm_data_o(dm_data_o),
        .dm_ready_o(dm_ready_o),
        .dm_err_o(dm_err_o),
        .bus_ce_o(bus_ce_o),
        .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o),
        .bus_data_o(bus_data_o),
        .bus_sel_o(bus_sel_o),
        .bus_data_i(bus_data_i),
        .bus_ack_i(bus_ack_i),
        .stallreq_o(stallreq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        flush_i    = 1'b0;
        if_ce_i    = 1'b0;
        if_addr_i  = '0;
        dm_ce_i    = 1'b0;
        dm_we_i    = 1'b0;
        dm_addr_i  = '0;
        dm_data_i  = '0;
        dm_sel_i   = '0;
        bus_data_i = '0;
        bus_ack_i  = 1'b0;
        #2;
        chk("rst_bus_ce", 32'(bus_ce_o), 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        chk("rst_if_ready", 32'(if_ready_o), 32'd0);
        chk("rst_dm_ready", 32'(dm_ready_o), 32'd0);
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        #10 rst = 1'b1;
        step();

        // fetch-only read, ack two cycles after bus_ce rises
        if_ce_i   = 1'b1;
        if_addr_i = 32'h0000_0100;
        #1;
        chk("f_stall_n", 32'(stallreq_o), 32'd1);
        chk("f_ce_n", 32'(bus_ce_o), 32'd0);
        step();
        chk("f_ce_n1", 32'(bus_ce_o), 32'd1);
        chk("f_addr", bus_addr_o, 32'h0000_0100);
        chk("f_sel", 32'(bus_sel_o), 32'hF);
        chk("f_we", 32'(bus_we_o), 32'd0);
        chk("f_stall_n1", 32'(stallreq_o), 32'd1);
        step();
        chk("f_ce_n2", 32'(bus_ce_o), 32'd1);
        chk("f_rdy_n2", 32'(if_ready_o), 32'd0);
        chk("f_stall_n2", 32'(stallreq_o), 32'd1);
        step();
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h3401_0020;
        chk("f_stall_n3", 32'(stallreq_o), 32'd1);
        step();
        bus_ack_i  = 1'b0;
        bus_data_i = '0;
        chk("f_rdy", 32'(if_ready_o), 32'd1);
        chk("f_data", if_data_o, 32'h3401_0020);
        chk("f_err", 32'(if_err_o), 32'd0);
        chk("f_ce_done", 32'(bus_ce_o), 32'd0);
        chk("f_stall_done", 32'(stallreq_o), 32'd0);
        if_ce_i = 1'b0;
        step();
        chk("f_rdy_once", 32'(if_ready_o), 32'd0);
        chk("f_data_hold", if_data_o, 32'h3401_0020);

        // store
        dm_ce_i   = 1'b1;
        dm_we_i   = 1'b1;
        dm_addr_i = 32'h0000_2004;
        dm_data_i = 32'hDEAD_BEEF;
        dm_sel_i  = 4'b0011;
        step();
        chk("s_ce", 32'(bus_ce_o), 32'd1);
        chk("s_we", 32'(bus_we_o), 32'd1);
        chk("s_addr", bus_addr_o, 32'h0000_2004);
        chk("s_data", bus_data_o, 32'hDEAD_BEEF);
        chk("s_sel", 32'(bus_sel_o), 32'h3);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h5555_5555;
        step();
        bus_ack_i  = 1'b0;
        bus_data_i = '0;
        chk("s_rdy", 32'(dm_ready_o), 32'd1);
        chk("s_dmdata", dm_data_o, 32'h0);
        chk("s_err", 32'(dm_err_o), 32'd0);
        chk("s_we_off", 32'(bus_we_o), 32'd0);
        dm_ce_i  = 1'b0;
        dm_we_i  = 1'b0;
        dm_sel_i = 4'b0000;
        step();
        chk("s_rdy_once", 32'(dm_ready_o), 32'd0);

        // simultaneous requests, data wins; slave acks immediately
        if_ce_i   = 1'b1;
        if_addr_i = 32'h0000_0300;
        dm_ce_i   = 1'b1;
        dm_addr_i = 32'h0000_2000;
        step();
        chk("sim_ce_n1", 32'(bus_ce_o), 32'd1);
        chk("sim_addr_n1", bus_addr_o, 32'h0000_2000);
        chk("sim_we_n1", 32'(bus_we_o), 32'd0);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h1122_3344;
        step();
        bus_ack_i  = 1'b0;
        bus_data_i = '0;
        chk("sim_dmrdy_n2", 32'(dm_ready_o), 32'd1);
        chk("sim_ifrdy_n2", 32'(if_ready_o), 32'd0);
        chk("sim_dmdata", dm_data_o, 32'h1122_3344);
        chk("sim_ce_n2", 32'(bus_ce_o), 32'd0);
        dm_ce_i = 1'b0;
        step();
        chk("sim_ce_n3", 32'(bus_ce_o), 32'd0);
        chk("sim_dmrdy_n3", 32'(dm_ready_o), 32'd0);
        step();
        chk("sim_ce_n4", 32'(bus_ce_o), 32'd1);
        chk("sim_addr_n4", bus_addr_o, 32'h0000_0300);
        chk("sim_sel_n4", 32'(bus_sel_o), 32'hF);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h0000_5678;
        step();
        bus_ack_i  = 1'b0;
        bus_data_i = '0;
        chk("sim_ifrdy", 32'(if_ready_o), 32'd1);
        chk("sim_ifdata", if_data_o, 32'h0000_5678);
        chk("sim_dmdata_hold", dm_data_o, 32'h1122_3344);
        if_ce_i = 1'b0;
        step();

        // flush while the fetch is on the bus
        if_ce_i   = 1'b1;
        if_addr_i = 32'h0000_0180;
        step();
        chk("fl_ce_n1", 32'(bus_ce_o), 32'd1);
        chk("fl_addr_n1", bus_addr_o, 32'h0000_0180);
        flush_i   = 1'b1;
        if_addr_i = 32'h0000_0200;
        #1;
        chk("fl_stall_flush", 32'(stallreq_o), 32'd0);
        step();
        flush_i = 1'b0;
        chk("fl_ce_n2", 32'(bus_ce_o), 32'd1);
        chk("fl_rdy_n2", 32'(if_ready_o), 32'd0);
        step();
        chk("fl_ce_n3", 32'(bus_ce_o), 32'd1);
        chk("fl_rdy_n3", 32'(if_ready_o), 32'd0);
        step();
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hBAD0_BAD0;
        step();
        bus_ack_i  = 1'b0;
        bus_data_i = '0;
        chk("fl_rdy_n5", 32'(if_ready_o), 32'd0);
        chk("fl_err_n5", 32'(if_err_o), 32'd0);
        chk("fl_ce_n5", 32'(bus_ce_o), 32'd0);
        chk("fl_data_kept", if_data_o, 32'h0000_5678);
        step();
        chk("fl_ce_n6", 32'(bus_ce_o), 32'd1);
        chk("fl_addr_n6", bus_addr_o, 32'h0000_0200);
        chk("fl_rdy_n6", 32'(if_ready_o), 32'd0);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h0000_AAAA;
        step();
        bus_ack_i  = 1'b0;
        bus_data_i = '0;
        chk("fl_rdy_new", 32'(if_ready_o), 32'd1);
        chk("fl_data_new", if_data_o, 32'h0000_AAAA);
        if_ce_i = 1'b0;
        step();

        // watchdog: load with no ack, four-cycle limit
        dm_ce_i   = 1'b1;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h0000_3000;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_ce_%0d", i), 32'(bus_ce_o), 32'd1);
            chk($sformatf("to_rdy_%0d", i), 32'(dm_ready_o), 32'd0);
            step();
        end
        chk("to_ce_end", 32'(bus_ce_o), 32'd0);
        chk("to_rdy", 32'(dm_ready_o), 32'd1);
        chk("to_err", 32'(dm_err_o), 32'd1);
        chk("to_data", dm_data_o, 32'h0);
        chk("to_ifrdy", 32'(if_ready_o), 32'd0);
        dm_ce_i = 1'b0;
        step();
        chk("to_rdy_once", 32'(dm_ready_o), 32'd0);
        chk("to_err_once", 32'(dm_err_o), 32'd0);

        // asynchronous reset in the middle of a data access
        dm_ce_i   = 1'b1;
        dm_addr_i = 32'h0000_4000;
        step();
        chk("rm_ce_before", 32'(bus_ce_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rm_ce", 32'(bus_ce_o), 32'd0);
        chk("rm_addr", bus_addr_o, 32'h0);
        chk("rm_ifdata", if_data_o, 32'h0);
        chk("rm_dmrdy", 32'(dm_ready_o), 32'd0);
        dm_ce_i = 1'b0;
        #1;
        chk("rm_stall", 32'(stallreq_o), 32'd0);
        step();
        #3 rst = 1'b1;
        step();
        step();
        chk("rm_idle_ce", 32'(bus_ce_o), 32'd0);
        chk("rm_idle_stall", 32'(stallreq_o), 32'd0);
        dm_ce_i   = 1'b1;
        dm_addr_i = 32'h0000_5000;
        step();
        chk("rm_regrant_ce", 32'(bus_ce_o), 32'd1);
        chk("rm_regrant_addr", bus_addr_o, 32'h0000_5000);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hCAFE_0001;
        step();
        bus_ack_i = 1'b0;
        chk("rm_rdy", 32'(dm_ready_o), 32'd1);
        chk("rm_data", dm_data_o, 32'hCAFE_0001);
        dm_ce_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
